// File: rtl/tb_col_packer_if.sv
// Output-side word stream of the column packer: head-of-queue word,
// its column count and buffer-half tag, plus the ready/valid pair.
interface tb_col_packer_if #(
   parameter int DATA_W = 12,
   parameter int CNT_W  = 3
);
   // Handshake: a word transfers on every rising clk edge where out_valid
   // and out_ready are both high; out_valid never depends on out_ready,
   // and the head word holds steady while out_valid=1 and out_ready=0.
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  out_count;
   logic              out_buf;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_data,
      output out_count,
      output out_buf,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_count,
      input  out_buf,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/tb_col_packer.sv
// Packs consecutive same-half columns from the transpose buffer into
// multi-column words and hands them out through a small FIFO. The source
// cannot be stalled, so a word arriving at a full queue is dropped and
// flagged on the sticky overflow output.
module tb_col_packer #(
   parameter int COL_WIDTH     = 3,
   parameter int COLS_PER_WORD = 4,
   parameter int QUEUE_DEPTH   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [COL_WIDTH-1:0] col_pixels,
   input  logic                 col_valid,
   input  logic                 col_buf,
   input  logic                 flush,
   tb_col_packer_if.master      out_if,
   output logic                 overflow,
   output logic [15:0]          cols_accepted
);

   localparam int DATA_W = COL_WIDTH * COLS_PER_WORD;
   localparam int CNT_W  = $clog2(COLS_PER_WORD + 1);
   localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(COLS_PER_WORD);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(COLS_PER_WORD - 1);
   localparam logic [PTR_W:0]   Q_FULL    = (PTR_W + 1)'(QUEUE_DEPTH);

   // Word assembly state
   logic [DATA_W-1:0] acc, acc_nxt, written;
   logic [CNT_W-1:0]  fill, fill_nxt;
   logic              acc_buf, acc_buf_nxt;
   logic              buf_switch;

   // Word offered to the queue this cycle (at most one)
   logic              push_req;
   logic [DATA_W-1:0] push_data;
   logic [CNT_W-1:0]  push_count;
   logic              push_buf;

   // Queue state
   logic [DATA_W-1:0] q_data  [QUEUE_DEPTH];
   logic [CNT_W-1:0]  q_count [QUEUE_DEPTH];
   logic              q_buf   [QUEUE_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [PTR_W:0]    q_used;
   logic              q_full, pop, do_push, not_empty;

   // Merge the incoming column, decide whether a word closes, then let a
   // flush close whatever partial word is left (never a second push).
   always_comb begin
      acc_nxt     = acc;
      fill_nxt    = fill;
      acc_buf_nxt = acc_buf;
      push_req    = 1'b0;
      push_data   = '0;
      push_count  = '0;
      push_buf    = 1'b0;
      buf_switch  = col_valid && (fill != '0) && (col_buf != acc_buf);
      written     = acc;
      written[int'(fill)*COL_WIDTH +: COL_WIDTH] = col_pixels;

      if (buf_switch) begin
         push_req    = 1'b1;
         push_data   = acc;
         push_count  = fill;
         push_buf    = acc_buf;
         acc_nxt     = '0;
         acc_nxt[COL_WIDTH-1:0] = col_pixels;
         fill_nxt    = CNT_W'(1);
         acc_buf_nxt = col_buf;
      end else if (col_valid) begin
         if (fill == '0) begin
            acc_buf_nxt = col_buf;
         end
         if (fill == LAST_SLOT) begin
            push_req   = 1'b1;
            push_data  = written;
            push_count = FULL_CNT;
            push_buf   = acc_buf_nxt;
            acc_nxt    = '0;
            fill_nxt   = '0;
         end else begin
            acc_nxt  = written;
            fill_nxt = fill + CNT_W'(1);
         end
      end

      if (flush && !push_req && (fill_nxt != '0)) begin
         push_req   = 1'b1;
         push_data  = acc_nxt;
         push_count = fill_nxt;
         push_buf   = acc_buf_nxt;
         acc_nxt    = '0;
         fill_nxt   = '0;
      end
   end

   // Assembly registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         fill    <= '0;
         acc_buf <= 1'b0;
      end else begin
         acc     <= acc_nxt;
         fill    <= fill_nxt;
         acc_buf <= acc_buf_nxt;
      end
   end

   assign not_empty = (q_used != '0);
   assign q_full    = (q_used == Q_FULL);
   assign pop       = not_empty && out_if.out_ready;
   // A full queue still takes the word when the head leaves this cycle.
   assign do_push   = push_req && (!q_full || pop);

   // Queue pointers, occupancy and the sticky drop flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         q_used   <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_push && !pop) begin
            q_used <= q_used + (PTR_W + 1)'(1);
         end else if (pop && !do_push) begin
            q_used <= q_used - (PTR_W + 1)'(1);
         end
         if (push_req && !do_push) begin
            overflow <= 1'b1;
         end
      end
   end

   // Queue storage; contents only matter behind the occupancy count
   always_ff @(posedge clk) begin
      if (do_push) begin
         q_data[wr_ptr]  <= push_data;
         q_count[wr_ptr] <= push_count;
         q_buf[wr_ptr]   <= push_buf;
      end
   end

   // Column counter, unaffected by dropped words
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cols_accepted <= '0;
      end else if (col_valid) begin
         cols_accepted <= cols_accepted + 16'd1;
      end
   end

   // Head word is forced to zero while empty so nothing is X after reset.
   assign out_if.out_valid = not_empty;
   assign out_if.out_data  = not_empty ? q_data[rd_ptr]  : '0;
   assign out_if.out_count = not_empty ? q_count[rd_ptr] : '0;
   assign out_if.out_buf   = not_empty ? q_buf[rd_ptr]   : 1'b0;

endmodule
